// File: rtl/imem_arbiter.sv
// imem_arbiter: arbitrates one single-port instruction memory between an
// instruction-fetch port and a debug/loader port.
//
// Ports
//   clk, reset          sole clock; synchronous active-high reset
//   f_req/f_addr        fetch read request, byte address
//   f_gnt               fetch accepted this cycle (combinational)
//   f_rvalid/f_rdata    fetch read response, one cycle after f_gnt
//   f_err               misaligned fetch address, pulsed with f_rvalid
//   d_req/d_we/d_addr/d_wdata  debug read/write request
//   d_lock              debug exclusive access; halts fetch while held
//   d_gnt               debug accepted this cycle (combinational)
//   d_rvalid/d_rdata    debug read response (reads only)
//   locked              high while the arbiter is in LOCK
//   mem_*               memory port; mem_rdata valid one cycle after a read
//
// Fetch wins arbitration in RUN, but a waiting debug request is forced
// through after STARVE_MAX consecutive fetch grants.
module imem_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int AW         = 14
) (
   input  logic          clk,
   input  logic          reset,
   // fetch port
   input  logic          f_req,
   input  logic [31:0]   f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [31:0]   f_rdata,
   output logic          f_err,
   // debug / loader port
   input  logic          d_req,
   input  logic          d_we,
   input  logic [31:0]   d_addr,
   input  logic [31:0]   d_wdata,
   input  logic          d_lock,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,
   output logic          locked,
   // memory port
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   localparam int            SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef enum logic {RUN, LOCK} state_t;

   state_t        state_q;
   logic [SW-1:0] starve_q, starve_d;

   // Read-response pipeline: one stage, matching the memory's latency.
   logic          f_pend_q;
   logic          f_mis_q;
   logic          d_pend_q;
   logic [31:0]   f_hold_q;
   logic [31:0]   d_hold_q;

   logic          f_gnt_c, d_gnt_c;

   // Only the word index of each address reaches the memory; the upper
   // bits wrap and the debug byte offset is meaningless.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{f_addr[31:AW+2], d_addr[31:AW+2], d_addr[1:0]};

   // ---------------------------------------------------------------
   // Arbitration (combinational). Reset masks every grant.
   // ---------------------------------------------------------------
   always_comb begin
      f_gnt_c = 1'b0;
      d_gnt_c = 1'b0;
      if (!reset) begin
         if (state_q == LOCK) begin
            d_gnt_c = d_req;
         end else begin
            d_gnt_c = d_req & (~f_req | (starve_q == STARVE_LIM));
            f_gnt_c = f_req & ~d_gnt_c;
         end
      end
   end

   // Starvation counter: counts fetch wins over a waiting debug request.
   always_comb begin
      starve_d = starve_q;
      if (d_gnt_c || !d_req)
         starve_d = '0;
      else if (f_gnt_c && (starve_q != STARVE_LIM))
         starve_d = starve_q + 1'b1;
   end

   // ---------------------------------------------------------------
   // Memory port: at most one grant, so a simple priority mux suffices.
   // ---------------------------------------------------------------
   always_comb begin
      mem_en    = f_gnt_c | d_gnt_c;
      mem_we    = d_gnt_c & d_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (d_gnt_c) begin
         mem_addr = d_addr[AW+1:2];
         if (d_we)
            mem_wdata = d_wdata;
      end else if (f_gnt_c) begin
         mem_addr = f_addr[AW+1:2];
      end
   end

   // ---------------------------------------------------------------
   // State: FSM, starvation counter, response pipeline, data holds.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         starve_q <= '0;
         f_pend_q <= 1'b0;
         f_mis_q  <= 1'b0;
         d_pend_q <= 1'b0;
         f_hold_q <= '0;
         d_hold_q <= '0;
      end else begin
         // LOCK follows d_lock with one edge of delay in both directions.
         case (state_q)
            RUN:     if (d_lock)  state_q <= LOCK;
            LOCK:    if (!d_lock) state_q <= RUN;
            default: state_q <= RUN;
         endcase
         starve_q <= starve_d;
         f_pend_q <= f_gnt_c;
         f_mis_q  <= f_gnt_c & (f_addr[1:0] != 2'b00);
         d_pend_q <= d_gnt_c & ~d_we;
         // Capture the delivered word so rdata holds once rvalid drops.
         if (f_pend_q) f_hold_q <= mem_rdata;
         if (d_pend_q) d_hold_q <= mem_rdata;
      end
   end

   // ---------------------------------------------------------------
   // Outputs. Responses pass mem_rdata straight through in the valid
   // cycle; reset suppresses any response due in the cycle it is high.
   // ---------------------------------------------------------------
   assign f_gnt    = f_gnt_c;
   assign d_gnt    = d_gnt_c;
   assign f_rvalid = f_pend_q & ~reset;
   assign d_rvalid = d_pend_q & ~reset;
   assign f_err    = f_mis_q & f_rvalid;
   assign f_rdata  = reset ? 32'h0 : (f_pend_q ? mem_rdata : f_hold_q);
   assign d_rdata  = reset ? 32'h0 : (d_pend_q ? mem_rdata : d_hold_q);
   assign locked   = (state_q == LOCK) & ~reset;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;
   localparam int AW = 14;
   localparam int SM = 4;
   localparam int MW = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          f_req, d_req, d_we, d_lock;
   logic [31:0]   f_addr, d_addr, d_wdata;
   logic          f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, locked;
   logic [31:0]   f_rdata, d_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   imem_arbiter #(.STARVE_MAX(SM), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .f_err(f_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .locked(locked),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Memory attached to the DUT; read data is garbage when not reading.
   logic [31:0] mem     [MW];
   logic [31:0] ref_mem [MW];
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      else if (mem_en)      mem_rdata <= mem[mem_addr];
      else                  mem_rdata <= $urandom;
   end

   int errs = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: applies the arbitration rules cycle by cycle and
   // remembers which response is owed next cycle and with what data.
   // ------------------------------------------------------------------
   bit            mon_en = 1'b0;
   bit            m_lock;
   int            m_starve;
   bit            pf_v, pf_e, pd_v;
   logic [31:0]   pf_d, pd_d, f_hold, d_hold;
   bit            eg_f, eg_d;
   logic [AW-1:0] fw, dw;

   always @(negedge clk) if (mon_en) begin
      if (reset) begin
         chk("rst_f_gnt", f_gnt, 0);   chk("rst_d_gnt", d_gnt, 0);
         chk("rst_mem_en", mem_en, 0); chk("rst_mem_we", mem_we, 0);
         chk("rst_f_rvalid", f_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
         chk("rst_f_err", f_err, 0);   chk("rst_locked", locked, 0);
         chk("rst_f_rdata", f_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
         m_lock = 0; m_starve = 0; pf_v = 0; pd_v = 0; f_hold = 0; d_hold = 0;
      end else begin
         if (m_lock) begin
            eg_d = d_req; eg_f = 0;
         end else begin
            eg_d = d_req && (!f_req || m_starve == SM);
            eg_f = f_req && !eg_d;
         end
         fw = AW'(f_addr >> 2);
         dw = AW'(d_addr >> 2);
         chk("m_f_gnt", f_gnt, eg_f);
         chk("m_d_gnt", d_gnt, eg_d);
         chk("m_mem_en", mem_en, eg_f || eg_d);
         chk("m_mem_we", mem_we, eg_d && d_we);
         chk("m_mem_addr", mem_addr, eg_d ? dw : (eg_f ? fw : '0));
         if (eg_d && d_we) chk("m_mem_wdata", mem_wdata, d_wdata);
         chk("m_locked", locked, m_lock);
         chk("m_f_rvalid", f_rvalid, pf_v);
         chk("m_f_err", f_err, pf_v && pf_e);
         chk("m_f_rdata", f_rdata, pf_v ? pf_d : f_hold);
         chk("m_d_rvalid", d_rvalid, pd_v);
         chk("m_d_rdata", d_rdata, pd_v ? pd_d : d_hold);
         if (pf_v) f_hold = pf_d;
         if (pd_v) d_hold = pd_d;
         pf_v = eg_f; pf_e = (f_addr[1:0] != 0); pf_d = ref_mem[fw];
         pd_v = eg_d && !d_we; pd_d = ref_mem[dw];
         if (eg_d && d_we) ref_mem[dw] = d_wdata;
         if (eg_d || !d_req) m_starve = 0;
         else if (eg_f && m_starve < SM) m_starve++;
         m_lock = d_lock;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_lock = 0;
      d_addr = 0; d_wdata = 0;
   endtask

   typedef struct {
      bit            fr;
      logic [31:0]   fa;
      bit            dr, dwe;
      logic [31:0]   da, dd;
      bit            e_fg, e_dg, e_we;
      logic [AW-1:0] e_addr;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int nf, hit;
      logic [31:0] w;
      reset = 1; idle();
      for (int i = 0; i < MW; i++) begin
         w = $urandom; mem[i] = w; ref_mem[i] = w;
      end
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[16] = 32'hCAFE0040;
      ref_mem[0] = 32'h11; ref_mem[1] = 32'h22; ref_mem[2] = 32'h33; ref_mem[16] = 32'hCAFE0040;
      mon_en = 1;
      repeat (3) step();
      #2;
      chk("reset_locked", locked, 0);
      chk("reset_f_rvalid", f_rvalid, 0);
      reset = 0;
      step();

      // single-cycle arbitration vectors from RUN with no starvation
      tbl[0] = '{1, 32'h0,        0, 0, 32'h0,   32'h0,        1, 0, 0, 14'h0};
      tbl[1] = '{1, 32'h6,        0, 0, 32'h0,   32'h0,        1, 0, 0, 14'h1};
      tbl[2] = '{1, 32'h0001_0004,0, 0, 32'h0,   32'h0,        1, 0, 0, 14'h1};
      tbl[3] = '{0, 32'h0,        1, 0, 32'h40,  32'h0,        0, 1, 0, 14'h10};
      tbl[4] = '{1, 32'h8,        1, 0, 32'h40,  32'h0,        1, 0, 0, 14'h2};
      tbl[5] = '{0, 32'h0,        1, 1, 32'h200, 32'h12345678, 0, 1, 1, 14'h80};
      tbl[6] = '{0, 32'h4,        0, 1, 32'h8,   32'h0,        0, 0, 0, 14'h0};
      tbl[7] = '{1, 32'hFFFF_FFFC,0, 0, 32'h0,   32'h0,        1, 0, 0, 14'h3FFF};
      for (int i = 0; i < 8; i++) begin
         f_req = tbl[i].fr; f_addr = tbl[i].fa; d_req = tbl[i].dr; d_we = tbl[i].dwe;
         d_addr = tbl[i].da; d_wdata = tbl[i].dd;
         #2;
         chk($sformatf("tbl%0d_f_gnt", i), f_gnt, tbl[i].e_fg);
         chk($sformatf("tbl%0d_d_gnt", i), d_gnt, tbl[i].e_dg);
         chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].e_we);
         chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
         step(); idle(); step();
      end

      // streaming fetch, one word per cycle
      f_req = 1; f_addr = 0; #2; chk("stream_gnt0", f_gnt, 1);
      step(); f_addr = 4; #2;
      chk("stream_gnt1", f_gnt, 1); chk("stream_rv0", f_rvalid, 1); chk("stream_d0", f_rdata, 32'h11);
      step(); f_addr = 8; #2;
      chk("stream_rv1", f_rvalid, 1); chk("stream_d1", f_rdata, 32'h22);
      step(); idle(); #2;
      chk("stream_rv2", f_rvalid, 1); chk("stream_d2", f_rdata, 32'h33);
      step(); #2; chk("stream_hold", f_rdata, 32'h33);
      step();

      // starvation limit: four fetch grants, then debug
      f_req = 1; f_addr = 32'hC; d_req = 1; d_addr = 32'h40;
      nf = 0; hit = 0;
      for (int c = 0; c < 10 && !hit; c++) begin
         #2;
         if (d_gnt) hit = c + 1;
         else if (f_gnt) nf++;
         step();
      end
      chk("starve_fgrants", nf, SM);
      chk("starve_dgnt_cycle", hit, SM + 1);
      #2;
      chk("starve_drvalid", d_rvalid, 1); chk("starve_drdata", d_rdata, 32'hCAFE0040);
      chk("starve_cleared_fgnt", f_gnt, 1);
      step(); idle(); step();

      // lock entry with a concurrent fetch, debug write, then read back
      d_lock = 1; d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
      f_req = 1; f_addr = 32'h20; #2;
      chk("lock_c0_fgnt", f_gnt, 1); chk("lock_c0_locked", locked, 0);
      step(); #2;
      chk("lock_c1_locked", locked, 1); chk("lock_c1_fgnt", f_gnt, 0);
      chk("lock_c1_mem_we", mem_we, 1); chk("lock_c1_addr", mem_addr, 14'h40);
      chk("lock_c1_frvalid", f_rvalid, 1);
      step(); idle(); #2;
      chk("lock_c2_locked", locked, 1); chk("lock_c2_drvalid", d_rvalid, 0);
      step(); f_req = 1; f_addr = 32'h100; #2;
      chk("unlock_locked", locked, 0); chk("unlock_fgnt", f_gnt, 1);
      step(); idle(); #2;
      chk("rdback_rv", f_rvalid, 1); chk("rdback_data", f_rdata, 32'hDEADBEEF);
      step();

      // misaligned fetch
      f_req = 1; f_addr = 32'h6; #2; chk("mis_addr", mem_addr, 14'h1);
      step(); idle(); #2;
      chk("mis_rv", f_rvalid, 1); chk("mis_err", f_err, 1);
      step(); #2; chk("mis_err_clr", f_err, 0);
      step();

      // reset the cycle after a fetch grant
      f_req = 1; f_addr = 32'h0; step();
      reset = 1; d_req = 1; #2;
      chk("rstmid_frv", f_rvalid, 0); chk("rstmid_fdata", f_rdata, 0);
      chk("rstmid_fgnt", f_gnt, 0); chk("rstmid_dgnt", d_gnt, 0);
      chk("rstmid_mem_en", mem_en, 0);
      step(); reset = 0; idle(); #2;
      chk("rstmid_after_rv", f_rvalid, 0);
      step();

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         f_req  = ($urandom_range(0, 9) < 7);
         f_addr = {$urandom_range(0, 3) == 0 ? 16'($urandom) : 16'h0,
                   8'h0, 6'($urandom_range(0, 15)), 2'($urandom_range(0, 3) == 0 ? $urandom : 0)};
         d_req  = ($urandom_range(0, 9) < 4);
         d_we   = ($urandom_range(0, 9) < 3);
         d_addr = {$urandom_range(0, 3) == 0 ? 16'($urandom) : 16'h0,
                   8'h0, 6'($urandom_range(0, 15)), 2'b00};
         d_wdata = $urandom;
         if ($urandom_range(0, 24) == 0) d_lock = ~d_lock;
         reset = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 0; idle();
      repeat (3) step();
      mon_en = 0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive fetch grants while a debug request waits.
REQ-002 SHALL have parameter AW, default 14: memory word-address width (16384 words).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 f_req  input  1  fetch port read request.
REQ-006 f_addr  input  32  fetch byte address.
REQ-007 f_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-008 f_rvalid  output  1  fetch read data valid.
REQ-009 f_rdata  output  32  fetch read data.
REQ-010 f_err  output  1  misaligned fetch address, pulsed with f_rvalid.
REQ-011 d_req  input  1  debug/loader port request.
REQ-012 d_we  input  1  debug write (1) or read (0).
REQ-013 d_addr  input  32  debug byte address.
REQ-014 d_wdata  input  32  debug write data.
REQ-015 d_lock  input  1  debug exclusive-access request (halts fetch).
REQ-016 d_gnt  output  1  debug request accepted this cycle (combinational).
REQ-017 d_rvalid  output  1  debug read data valid (reads only).
REQ-018 d_rdata  output  32  debug read data.
REQ-019 locked  output  1  high while state is LOCK.
REQ-020 mem_en  output  1  memory access enable.
REQ-021 mem_we  output  1  memory write enable.
REQ-022 mem_addr  output  AW  memory word index = granted byte address [AW+1:2].
REQ-023 mem_wdata  output  32  memory write data.
REQ-024 mem_rdata  input  32  memory read data, valid one cycle after mem_en read.

Function
REQ-025 SHALL implement FSM states RUN and LOCK; reset state RUN.
REQ-026 RUN->LOCK on the edge where d_lock=1 is sampled; LOCK->RUN on the edge where d_lock=0 is sampled.
REQ-027 In LOCK: f_gnt=0 always; d_gnt=d_req.
REQ-028 In RUN: fetch has priority; d_gnt=d_req & (~f_req | starve_cnt==STARVE_MAX); f_gnt=f_req & ~d_gnt.
REQ-029 starve_cnt SHALL increment (saturating at STARVE_MAX) on each f_gnt cycle while d_req=1, and clear to 0 on any d_gnt or any cycle with d_req=0.
REQ-030 At most one grant per cycle; mem_en=f_gnt|d_gnt; mem_we=d_gnt&d_we; address/wdata muxed from granted port; all mem_* outputs 0 when idle.
REQ-031 Read latency exactly 1 cycle: f_rvalid/d_rvalid asserted the cycle after a read grant, f_rdata/d_rdata=mem_rdata in that cycle; back-to-back reads sustain one per cycle.
REQ-032 Debug writes SHALL produce no d_rvalid.
REQ-033 f_err SHALL equal registered (f_addr[1:0]!=0) of the granted fetch, asserted only with f_rvalid; the access still proceeds with truncated address.
REQ-034 Address bits above AW+1 SHALL be ignored (wrap modulo memory size).
REQ-035 Simultaneous d_lock rise and f_req in RUN: fetch arbitration per REQ-028 that cycle; LOCK effective next cycle.
REQ-036 A fetch read granted on the cycle before LOCK entry SHALL still return f_rvalid in the first LOCK cycle.
REQ-037 d_rdata/f_rdata SHALL hold last value when corresponding rvalid=0.

Reset
REQ-038 reset=1 SHALL force state RUN, starve_cnt=0, f_rvalid=0, d_rvalid=0, f_err=0, f_rdata=0, d_rdata=0, locked=0, and cancel any pending read response.
REQ-039 While reset=1, f_gnt, d_gnt, mem_en and mem_we SHALL be 0 regardless of requests.
REQ-040 Reset asserted mid-read SHALL suppress the rvalid due the following cycle.

Verification
REQ-041 f_req=1 continuously, f_addr=0,4,8; memory words 0x11,0x22,0x33 -> f_gnt each cycle, f_rvalid one cycle later with 0x11,0x22,0x33 in order.
REQ-042 f_req=1 and d_req=1 (read 0x40) held -> 4 fetch grants, then d_gnt on 5th cycle, d_rvalid next cycle, starve_cnt back to 0.
REQ-043 d_lock=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF with f_req=1 -> locked=1 next cycle, f_gnt=0, mem_we=1 at word 0x40; later fetch at 0x100 returns 0xDEADBEEF.
REQ-044 Fetch f_addr=0x6 -> mem_addr=1, f_rvalid=1 with f_err=1 next cycle.
REQ-045 Fetch read granted, reset=1 next cycle -> f_rvalid stays 0, all outputs at reset values.
REQ-046 f_addr=0x0001_0004 -> mem_addr=1 (upper bits ignored).
